// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding select encodings,
// memory-wait FSM states and the default register index width.
package pipeline_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG    = 2'b00;
  localparam fwd_sel_t FWD_EX_MEM = 2'b01;
  localparam fwd_sel_t FWD_MEM_WB = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_wait_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-latch observations and control outputs exchanged between
// the datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 16
);

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_is_branch;
  logic                  branch_taken;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_rw;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] mem_rw;
  logic                  mem_reg_write;
  logic                  mem_mem_read;
  logic [REG_ADDR_W-1:0] wb_rw;
  logic                  wb_reg_write;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_write;
  logic                  ex_mem_write;
  logic                  if_id_flush;
  logic                  id_ex_bubble;
  logic                  mem_wb_bubble;
  fwd_sel_t              fwd_sel_a;
  fwd_sel_t              fwd_sel_b;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
    output ex_rs, ex_rt, ex_rw, ex_reg_write, ex_mem_read,
    output mem_rw, mem_reg_write, mem_mem_read, wb_rw, wb_reg_write,
    output mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
    input  if_id_flush, id_ex_bubble, mem_wb_bubble,
    input  fwd_sel_a, fwd_sel_b, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
    input  ex_rs, ex_rt, ex_rw, ex_reg_write, ex_mem_read,
    input  mem_rw, mem_reg_write, mem_mem_read, wb_rw, wb_reg_write,
    input  mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
    output if_id_flush, id_ex_bubble, mem_wb_bubble,
    output fwd_sel_a, fwd_sel_b, mem_timeout, stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// EX operand forwarding select for one source register; EX/MEM wins over MEM/WB,
// but a load in EX/MEM has no result yet and falls through to MEM/WB.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] ex_mem_rw,
  input  logic                  ex_mem_reg_write,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_wb_rw,
  input  logic                  mem_wb_reg_write,
  output fwd_sel_t              sel
);

  logic src_live;
  logic ex_mem_hit;
  logic mem_wb_hit;

  assign src_live   = (src != '0);
  assign ex_mem_hit = src_live && ex_mem_reg_write && (src == ex_mem_rw);
  assign mem_wb_hit = src_live && mem_wb_reg_write && (src == mem_wb_rw);

  always_comb begin
    sel = FWD_REG;
    if (ex_mem_hit && !ex_mem_mem_read) begin
      sel = FWD_EX_MEM;
    end else if (mem_wb_hit) begin
      sel = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the five-stage pipeline: load-use
// and branch-operand stalls, taken-branch flush, memory-wait freeze with timeout.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input logic                 clock,
  input logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] src,
                                     input logic [REG_ADDR_W-1:0] dst,
                                     input logic                  wr);
    return wr && (src != '0) && (src == dst);
  endfunction

  logic id_ex_hit;
  logic id_mem_hit;
  logic load_use;
  logic branch_stall;
  logic stall;
  logic freeze;

  mem_wait_state_t   state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_q, timeout_nxt;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic pc_write;
  logic if_id_write;
  logic id_ex_write;
  logic ex_mem_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic mem_wb_bubble;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src              (hz.ex_rs),
    .ex_mem_rw        (hz.mem_rw),
    .ex_mem_reg_write (hz.mem_reg_write),
    .ex_mem_mem_read  (hz.mem_mem_read),
    .mem_wb_rw        (hz.wb_rw),
    .mem_wb_reg_write (hz.wb_reg_write),
    .sel              (hz.fwd_sel_a)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src              (hz.ex_rt),
    .ex_mem_rw        (hz.mem_rw),
    .ex_mem_reg_write (hz.mem_reg_write),
    .ex_mem_mem_read  (hz.mem_mem_read),
    .mem_wb_rw        (hz.wb_rw),
    .mem_wb_reg_write (hz.wb_reg_write),
    .sel              (hz.fwd_sel_b)
  );

  assign id_ex_hit  = (hz.id_uses_rs && reg_match(hz.id_rs, hz.ex_rw, hz.ex_reg_write)) ||
                      (hz.id_uses_rt && reg_match(hz.id_rt, hz.ex_rw, hz.ex_reg_write));
  assign id_mem_hit = (hz.id_uses_rs && reg_match(hz.id_rs, hz.mem_rw, hz.mem_reg_write)) ||
                      (hz.id_uses_rt && reg_match(hz.id_rt, hz.mem_rw, hz.mem_reg_write));

  // A branch compares in ID, so it must also wait out any EX result and a load still in MEM.
  assign load_use     = hz.ex_mem_read && id_ex_hit;
  assign branch_stall = hz.id_is_branch && (id_ex_hit || (hz.mem_mem_read && id_mem_hit));
  assign stall        = load_use || branch_stall;
  assign freeze       = hz.mem_req && !hz.mem_ready;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
    end else if (hz.branch_taken) begin
      if_id_flush   = 1'b1;
    end
  end

  // Memory-wait FSM: wait_cnt counts frozen cycles and parks at its last value once timed out.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = timeout_q;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) timeout_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (!freeze) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.pc_write      = pc_write;
  assign hz.if_id_write   = if_id_write;
  assign hz.id_ex_write   = id_ex_write;
  assign hz.ex_mem_write  = ex_mem_write;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_bubble  = id_ex_bubble;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.mem_timeout   = timeout_q;
  assign hz.stall_cycles  = stall_q;
  assign hz.flush_count   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared cycle by cycle against a model.
module tb_pipeline_hazard_ctrl;

  localparam int RW   = 5;
  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: consecutive frozen cycles, sticky timeout, counters.
  int m_frozen = 0;
  bit m_to     = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Classify the current cycle from the rules: which destinations block ID, is it frozen.
  function automatic void classify(output bit frz, output bit stl, output bit fl);
    int blockers[$];
    int srcs[$];
    frz = bus.mem_req && !bus.mem_ready;
    if (bus.ex_reg_write && (bus.ex_mem_read || bus.id_is_branch)) blockers.push_back(int'(bus.ex_rw));
    if (bus.id_is_branch && bus.mem_mem_read && bus.mem_reg_write) blockers.push_back(int'(bus.mem_rw));
    if (bus.id_uses_rs) srcs.push_back(int'(bus.id_rs));
    if (bus.id_uses_rt) srcs.push_back(int'(bus.id_rt));
    stl = 1'b0;
    foreach (srcs[i]) foreach (blockers[j]) if (srcs[i] != 0 && srcs[i] == blockers[j]) stl = 1'b1;
    fl = bus.branch_taken && !stl && !frz;
  endfunction

  function automatic int fwd_expect(input int src);
    if (src != 0 && bus.mem_reg_write && !bus.mem_mem_read && src == int'(bus.mem_rw)) return 1;
    if (src != 0 && bus.wb_reg_write && src == int'(bus.wb_rw)) return 2;
    return 0;
  endfunction

  always @(posedge clock) begin
    bit frz, stl, fl;
    classify(frz, stl, fl);
    if (reset) begin
      m_frozen <= 0;
      m_to     <= 1'b0;
      m_stall  <= 0;
      m_flush  <= 0;
    end else begin
      if (frz) begin
        m_frozen <= m_frozen + 1;
        if (m_frozen + 1 >= TO) m_to <= 1'b1;
      end else begin
        m_frozen <= 0;
      end
      if (frz || stl) m_stall <= (m_stall < MAXC) ? m_stall + 1 : MAXC;
      if (fl)         m_flush <= (m_flush < MAXC) ? m_flush + 1 : MAXC;
    end
  end

  always @(negedge clock) begin
    bit frz, stl, fl;
    if (chk_en) begin
      classify(frz, stl, fl);
      check("pc_write",      bus.pc_write,      !(frz || stl));
      check("if_id_write",   bus.if_id_write,   !(frz || stl));
      check("id_ex_write",   bus.id_ex_write,   !frz);
      check("ex_mem_write",  bus.ex_mem_write,  !frz);
      check("id_ex_bubble",  bus.id_ex_bubble,  stl && !frz);
      check("mem_wb_bubble", bus.mem_wb_bubble, frz);
      check("if_id_flush",   bus.if_id_flush,   fl);
      check("fwd_sel_a",     bus.fwd_sel_a,     fwd_expect(int'(bus.ex_rs)));
      check("fwd_sel_b",     bus.fwd_sel_b,     fwd_expect(int'(bus.ex_rt)));
      check("mem_timeout",   bus.mem_timeout,   m_to);
      check("stall_cycles",  bus.stall_cycles,  m_stall);
      check("flush_count",   bus.flush_count,   m_flush);
    end
  end

  task automatic idle();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_is_branch = 0; bus.branch_taken = 0;
    bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_rw = '0; bus.ex_reg_write = 0; bus.ex_mem_read = 0;
    bus.mem_rw = '0; bus.mem_reg_write = 0; bus.mem_mem_read = 0;
    bus.wb_rw = '0; bus.wb_reg_write = 0;
    bus.mem_req = 0; bus.mem_ready = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_use_r5();
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rw = 5'd5;
    bus.id_rt = 5'd5; bus.id_uses_rt = 1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    chk_en = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_stall_cycles", bus.stall_cycles, 0);
    check("rst_flush_count",  bus.flush_count,  0);
    check("rst_mem_timeout",  bus.mem_timeout,  0);
    check("rst_pc_write",     bus.pc_write,     1);
    step();
    reset = 1'b0;

    // Forwarding priority
    bus.mem_rw = 5'd3; bus.mem_reg_write = 1; bus.wb_rw = 5'd3; bus.wb_reg_write = 1;
    bus.ex_rs = 5'd3;
    @(negedge clock);
    check("fwd_prio_exmem", bus.fwd_sel_a, 2'b01);
    step();
    bus.mem_mem_read = 1;
    @(negedge clock);
    check("fwd_load_memwb", bus.fwd_sel_a, 2'b10);
    step();
    idle();

    // r0 never matches
    bus.ex_rt = '0; bus.ex_rw = '0; bus.ex_reg_write = 1;
    bus.mem_rw = '0; bus.mem_reg_write = 1; bus.wb_rw = '0; bus.wb_reg_write = 1;
    @(negedge clock);
    check("fwd_r0", bus.fwd_sel_b, 2'b00);
    step();
    idle();

    // Load-use stall with a taken branch, then the branch re-resolves
    load_use_r5();
    bus.branch_taken = 1;
    @(negedge clock);
    check("lu_pc_write",     bus.pc_write,     0);
    check("lu_id_ex_bubble", bus.id_ex_bubble, 1);
    check("lu_if_id_flush",  bus.if_id_flush,  0);
    step();
    idle();
    bus.branch_taken = 1;
    @(negedge clock);
    check("lu_stall_cycles", bus.stall_cycles, 1);
    check("br_if_id_flush",  bus.if_id_flush,  1);
    step();
    idle();
    @(negedge clock);
    check("br_flush_count", bus.flush_count, 1);

    // Memory freeze through timeout
    for (int k = 1; k <= 5; k++) begin
      step();
      bus.mem_req = 1; bus.mem_ready = 0;
      @(negedge clock);
      check("frz_pc_write",      bus.pc_write,      0);
      check("frz_if_id_write",   bus.if_id_write,   0);
      check("frz_id_ex_write",   bus.id_ex_write,   0);
      check("frz_ex_mem_write",  bus.ex_mem_write,  0);
      check("frz_mem_wb_bubble", bus.mem_wb_bubble, 1);
      check("frz_mem_timeout",   bus.mem_timeout,   (k == 5));
    end
    step();
    bus.mem_ready = 1;
    @(negedge clock);
    check("rdy_pc_write",    bus.pc_write,    1);
    check("rdy_mem_timeout", bus.mem_timeout, 1);
    step();
    idle();
    @(negedge clock);
    check("sticky_timeout", bus.mem_timeout, 1);

    // Reset while waiting, request held high throughout
    step();
    bus.mem_req = 1;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("rstw_mem_timeout",  bus.mem_timeout,  0);
    check("rstw_stall_cycles", bus.stall_cycles, 0);
    check("rstw_flush_count",  bus.flush_count,  0);
    for (int k = 2; k <= 5; k++) begin
      step();
      @(negedge clock);
      check("rstw_recount", bus.mem_timeout, (k == 5));
    end
    step();
    idle();

    // Counter saturation
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_use_r5();
    repeat (14) @(posedge clock);
    @(negedge clock);
    check("sat_stall_14", bus.stall_cycles, 14);
    repeat (6) @(posedge clock);
    #1;
    idle();
    @(negedge clock);
    check("sat_stall_15", bus.stall_cycles, 15);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step();
      reset            = ($urandom_range(0, 49) == 0);
      bus.id_rs        = RW'($urandom_range(0, 3));
      bus.id_rt        = RW'($urandom_range(0, 3));
      bus.id_uses_rs   = 1'($urandom_range(0, 1));
      bus.id_uses_rt   = 1'($urandom_range(0, 1));
      bus.id_is_branch = 1'($urandom_range(0, 1));
      bus.branch_taken = bus.id_is_branch && ($urandom_range(0, 1) == 1);
      bus.ex_rs        = RW'($urandom_range(0, 3));
      bus.ex_rt        = RW'($urandom_range(0, 3));
      bus.ex_rw        = RW'($urandom_range(0, 3));
      bus.ex_reg_write = 1'($urandom_range(0, 1));
      bus.ex_mem_read  = 1'($urandom_range(0, 1));
      bus.mem_rw       = RW'($urandom_range(0, 3));
      bus.mem_reg_write= 1'($urandom_range(0, 1));
      bus.mem_mem_read = 1'($urandom_range(0, 1));
      bus.wb_rw        = RW'($urandom_range(0, 3));
      bus.wb_reg_write = 1'($urandom_range(0, 1));
      bus.mem_req      = 1'($urandom_range(0, 1));
      bus.mem_ready    = ($urandom_range(0, 3) == 0);
    end
    step();
    reset = 1'b0;
    idle();
    step();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
